// File: rtl/clk_mux_ctrl_pkg.sv
// Shared types and default constants for the dual-MMCM clock-mux sequencer.
// No logic; the state encodings are fixed because they are visible on the state port.
package clk_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RUN_INT   = 3'd2,
        ST_QUALIFY   = 3'd3,
        ST_RUN_EXT   = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int DEF_RST_CYCLES        = 16;
    localparam int DEF_LOCK_TIMEOUT      = 65535;
    localparam int DEF_EXT_STABLE_CYCLES = 4096;
    localparam int DEF_CNT_W             = 16;
    localparam int TMR_W                 = 32;

endpackage

// File: rtl/clk_mux_ctrl_if.sv
// Control/status bundle between the clock-mux sequencer and the clocking wrapper.
// master = sequencer side (drives status), slave = wrapper side (drives requests/health).
interface clk_mux_ctrl_if
    import clk_mux_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             restart;
    logic             force_int;
    logic             locked;
    logic             ext_active;
    logic             mmcm_nrst;
    logic             clk_int_select;
    logic             ext_in_use;
    logic             lock_fault;
    state_t           state;
    logic [CNT_W-1:0] switch_count;

    modport master (
        input  restart, force_int, locked, ext_active,
        output mmcm_nrst, clk_int_select, ext_in_use, lock_fault, state, switch_count
    );

    modport slave (
        output restart, force_int, locked, ext_active,
        input  mmcm_nrst, clk_int_select, ext_in_use, lock_fault, state, switch_count
    );
endinterface

// File: rtl/clk_mux_ctrl_sync.sv
// Purpose: 2-flop synchronizer for slow asynchronous status levels.
// Latency: 2 clk cycles. Backpressure: none, level signals only.
module clk_mux_ctrl_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] async_dat,
    output logic [WIDTH-1:0] sync_dat
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta     <= '0;
            sync_dat <= '0;
        end else begin
            meta     <= async_dat;
            sync_dat <= meta;
        end
    end
endmodule

// File: rtl/clk_mux_ctrl.sv
// Purpose: MMCM reset/lock sequencing and ext/int failover for the 320/40 MHz clock mux.
// Latency: async input edge to state change 3 cycles; all outputs registered. Backpressure: none.
// Option: CLK_MUX_CTRL_AUTO_FAILBACK_EN lets the mux return to external after a loss of ext clock.
module clk_mux_ctrl
    import clk_mux_ctrl_pkg::*;
#(
    parameter int RST_CYCLES        = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int EXT_STABLE_CYCLES = DEF_EXT_STABLE_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input logic            clk,
    input logic            nrst,
    clk_mux_ctrl_if.master bus
);
    logic             locked_s;
    logic             ext_s;
    logic             ext_ok;
    logic             fb_block;
    logic             set_fault;
    state_t           state_q;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_nxt;
    logic             mmcm_nrst_q;
    logic             int_sel_q;
    logic             ext_use_q;
    logic             lock_fault_q;
    logic [CNT_W-1:0] sw_cnt_q;

    clk_mux_ctrl_sync #(.WIDTH(1)) u_sync_lock (
        .clk(clk), .nrst(nrst), .async_dat(bus.locked), .sync_dat(locked_s)
    );

    clk_mux_ctrl_sync #(.WIDTH(1)) u_sync_ext (
        .clk(clk), .nrst(nrst), .async_dat(bus.ext_active), .sync_dat(ext_s)
    );

    assign ext_ok = ext_s && !bus.force_int;

`ifdef CLK_MUX_CTRL_AUTO_FAILBACK_EN
    assign fb_block = 1'b0;
`else
    logic fb_block_q;

    // Once the external clock has dropped out, stay on internal until an operator restart.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fb_block_q <= 1'b0;
        end else if (bus.restart) begin
            fb_block_q <= 1'b0;
        end else if (state_q == ST_RUN_EXT && !ext_s) begin
            fb_block_q <= 1'b1;
        end
    end

    assign fb_block = fb_block_q;
`endif

    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = '0;
        set_fault = 1'b0;
        case (state_q)
            ST_RESET: begin
                tmr_nxt = tmr_q + 1'b1;
                if (tmr_q == TMR_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                tmr_nxt = tmr_q + 1'b1;
                if (locked_s) begin
                    state_nxt = ST_RUN_INT;
                end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = ST_FAULT;
                    set_fault = 1'b1;
                end
            end
            ST_RUN_INT: begin
                if (!locked_s)                 state_nxt = ST_RESET;
                else if (ext_ok && !fb_block)  state_nxt = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                tmr_nxt = tmr_q + 1'b1;
                if (!locked_s)                                      state_nxt = ST_RESET;
                else if (!ext_ok)                                   state_nxt = ST_RUN_INT;
                else if (tmr_q == TMR_W'(EXT_STABLE_CYCLES - 1))    state_nxt = ST_RUN_EXT;
            end
            ST_RUN_EXT: begin
                if (!locked_s)    state_nxt = ST_RESET;
                else if (!ext_ok) state_nxt = ST_RUN_INT;
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_RESET;
        endcase
        // Every state entry starts its timer from zero, including a restart while already in RESET.
        if (bus.restart) begin
            state_nxt = ST_RESET;
            set_fault = 1'b0;
        end
        if (bus.restart || state_nxt != state_q) tmr_nxt = '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_RESET;
            tmr_q        <= '0;
            mmcm_nrst_q  <= 1'b0;
            int_sel_q    <= 1'b1;
            ext_use_q    <= 1'b0;
            lock_fault_q <= 1'b0;
            sw_cnt_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            tmr_q       <= tmr_nxt;
            mmcm_nrst_q <= (state_nxt != ST_RESET);
            int_sel_q   <= (state_nxt != ST_RUN_EXT);
            ext_use_q   <= (state_nxt == ST_RUN_EXT);
            if (bus.restart)    lock_fault_q <= 1'b0;
            else if (set_fault) lock_fault_q <= 1'b1;
            // Entries and exits of RUN_EXT both count, whatever the exit destination.
            if (((state_q == ST_RUN_EXT) != (state_nxt == ST_RUN_EXT)) && (sw_cnt_q != '1))
                sw_cnt_q <= sw_cnt_q + 1'b1;
        end
    end

    assign bus.state          = state_q;
    assign bus.mmcm_nrst      = mmcm_nrst_q;
    assign bus.clk_int_select = int_sel_q;
    assign bus.ext_in_use     = ext_use_q;
    assign bus.lock_fault     = lock_fault_q;
    assign bus.switch_count   = sw_cnt_q;
endmodule
